matmul_tile_scheduler: RTL and testbench
========================================

# matmul_tile_scheduler

Tiles a full matrix multiply into systolic-array-sized sub-problems and sequences them through the multiply controller one at a time. It iterates over output row tiles, output column tiles and intermediate-dimension tiles, and issues a start pulse per tile. For each tile it provides tile indices, weight and data base addresses, and an accumulate-clear flag. It sits between the host command decoder and the per-tile multiply controller, and owns ordering and address generation for the whole operation.

## Interface
- SYS_ARR_DIM, 16, systolic array height/width; tile edge length
- MAX_OUT_ROWS, 128, maximum output rows
- MAX_OUT_COLS, 128, maximum output columns
- MAX_INTERMED, 128, maximum intermediate (K) dimension
- ADDR_W, 16, address width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; honoured only in IDLE
- num_out_rows  in  $clog2(MAX_OUT_ROWS+1)  output rows M
- num_out_cols  in  $clog2(MAX_OUT_COLS+1)  output cols N
- intermed_dim  in  $clog2(MAX_INTERMED+1)  K
- base_weight  in  ADDR_W  weight matrix base address
- base_data  in  ADDR_W  data matrix base address
- mult_done  in  1  per-tile completion pulse from multiply controller
- mult_start  out  1  per-tile start pulse
- tile_row  out  $clog2(MAX_OUT_ROWS/SYS_ARR_DIM)  current row tile
- tile_col  out  $clog2(MAX_OUT_COLS/SYS_ARR_DIM)  current col tile
- tile_k  out  $clog2(MAX_INTERMED/SYS_ARR_DIM)  current K tile
- weight_addr  out  ADDR_W  weight address of current tile
- data_addr  out  ADDR_W  data address of current tile
- accum_clear  out  1  high when tile_k==0 (overwrite rather than accumulate)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

## Operation
- In IDLE with start=1, latch M, N, K and both base addresses. Compute tile counts RT=ceil(M/SYS_ARR_DIM), CT=ceil(N/SYS_ARR_DIM) and KT=ceil(K/SYS_ARR_DIM).
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE.
  - IDLE→ISSUE on start, when all dimensions are nonzero.
  - IDLE→DONE on start, when any dimension is zero. No mult_start is issued.
  - ISSUE→WAIT unconditionally. mult_start=1 for this cycle only.
  - WAIT→ADVANCE on mult_done.
  - ADVANCE→ISSUE when tiles remain; ADVANCE→DONE after the last tile.
  - DONE→IDLE unconditionally. done=1 for this cycle only.
- Loop order: tile_k is innermost, then tile_col, then tile_row outermost. tile_k wraps at KT-1 and carries into tile_col; tile_col wraps at CT-1 and carries into tile_row.
- weight_addr = base_weight + (tile_k*CT + tile_col)*SYS_ARR_DIM.
- data_addr = base_data + (tile_row*KT + tile_k)*SYS_ARR_DIM.
- Both addresses are truncated modulo 2^ADDR_W; wrap is silent.
- accum_clear = (tile_k==0).
- start outside IDLE is ignored, and latched operands are unaffected.
- mult_done outside WAIT is ignored.
- Input dimensions above their MAX are clamped to MAX at latch time.

## Timing
- Reset values: mult_start=0, done=0, busy=0, accum_clear=0, and all tile indices and addresses 0. State is IDLE.
- Reset mid-operation aborts the sequence. Outputs return to reset values on the next edge, with no done pulse.
- Start accepted at cycle 0: busy=1 and mult_start=1 at cycle 1.
- mult_done seen at cycle t: ADVANCE at t+1, then the next mult_start at t+2, or done at t+2 after the last tile.
- tile_*, weight_addr, data_addr and accum_clear are registered. They are valid in the mult_start cycle and held stable until the ADVANCE edge.
- busy drops in the same cycle that done pulses.
- Zero-dimension start at cycle 0: done=1 at cycle 1, with no mult_start.

## Configuration
- MATMUL_TILE_SCHED_PERF_EN defined:
  - Adds output perf_cycles (32 bits), counting cycles with busy=1. It clears on accepted start and holds after done.
  - Adds output perf_tiles (16 bits), counting mult_start pulses.
- Undefined: neither port nor counter exists.

## Structure
- Shared package tpu_pkg holds:
  - the scheduler state enum;
  - SYS_ARR_DIM and the MAX_* defaults;
  - the tile-count ceil-divide function.
- One sub-module, tile_index_counter: a three-level wrapping counter with per-level limits, an advance input and a last-tile output. Address arithmetic stays in the top module.

## Test plan
- M=N=K=32 → 8 tiles issued in order (r,c,k) = 000,001,010,011,100,101,110,111. accum_clear=1 on k=0 tiles only. Tile (1,1,1) gives weight_addr=base_weight+48 and data_addr=base_data+48.
- M=N=K=16, mult_done returned 3 cycles after mult_start → single tile, done exactly 5 cycles after mult_start.
- M=20, N=16, K=40 → RT=2, KT=3, 6 tiles; the final tile is (1,0,2).
- K=0 with start → done at cycle 1, mult_start never asserted, busy stays 0.
- Reset asserted in WAIT of tile 3 → all outputs 0 next cycle. A new start (16,16,16) then completes normally. A start pulse during busy has no effect.
- With MATMUL_TILE_SCHED_PERF_EN defined, M=N=K=32 and mult_done 1 cycle after each mult_start → perf_tiles=8 and perf_cycles=24.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the matmul tile scheduler: FSM states, tile geometry
// defaults and the tile-count helper.
package tpu_pkg;

  localparam int SYS_ARR_DIM  = 16;
  localparam int MAX_OUT_ROWS = 128;
  localparam int MAX_OUT_COLS = 128;
  localparam int MAX_INTERMED = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } sched_state_e;

  // Number of tile_len-sized tiles needed to cover dim (ceil divide).
  function automatic int unsigned tile_count(input int unsigned dim,
                                             input int unsigned tile_len);
    return (dim + tile_len - 1) / tile_len;
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_counter.sv
// tile_index_counter: three-level wrapping index counter (k innermost, then
// col, then row) with per-level inclusive limits and a last-tile flag.
module tile_index_counter #(
  parameter int R_W = 3,
  parameter int C_W = 3,
  parameter int K_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  input  logic [R_W-1:0] lim_r,
  input  logic [C_W-1:0] lim_c,
  input  logic [K_W-1:0] lim_k,
  output logic [R_W-1:0] idx_r,
  output logic [C_W-1:0] idx_c,
  output logic [K_W-1:0] idx_k,
  output logic           last
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_r <= '0;
      idx_c <= '0;
      idx_k <= '0;
    end else if (advance) begin
      if (idx_k != lim_k) begin
        idx_k <= idx_k + 1'b1;
      end else begin
        idx_k <= '0;
        if (idx_c != lim_c) begin
          idx_c <= idx_c + 1'b1;
        end else begin
          idx_c <= '0;
          idx_r <= (idx_r == lim_r) ? '0 : idx_r + 1'b1;
        end
      end
    end
  end

  assign last = (idx_r == lim_r) && (idx_c == lim_c) && (idx_k == lim_k);

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Sequences a full matmul as SYS_ARR_DIM-sized tiles through the multiply
// controller. Optional perf counters under MATMUL_TILE_SCHED_PERF_EN.
module matmul_tile_scheduler #(
  parameter int SYS_ARR_DIM  = tpu_pkg::SYS_ARR_DIM,
  parameter int MAX_OUT_ROWS = tpu_pkg::MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = tpu_pkg::MAX_OUT_COLS,
  parameter int MAX_INTERMED = tpu_pkg::MAX_INTERMED,
  parameter int ADDR_W       = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [$clog2(MAX_OUT_ROWS+1)-1:0]             num_out_rows,
  input  logic [$clog2(MAX_OUT_COLS+1)-1:0]             num_out_cols,
  input  logic [$clog2(MAX_INTERMED+1)-1:0]             intermed_dim,
  input  logic [ADDR_W-1:0]                             base_weight,
  input  logic [ADDR_W-1:0]                             base_data,
  input  logic                                          mult_done,
  output logic                                          mult_start,
  output logic [$clog2(MAX_OUT_ROWS/SYS_ARR_DIM)-1:0]   tile_row,
  output logic [$clog2(MAX_OUT_COLS/SYS_ARR_DIM)-1:0]   tile_col,
  output logic [$clog2(MAX_INTERMED/SYS_ARR_DIM)-1:0]   tile_k,
  output logic [ADDR_W-1:0]                             weight_addr,
  output logic [ADDR_W-1:0]                             data_addr,
  output logic                                          accum_clear,
  output logic                                          busy,
  output logic                                          done,
  output logic [2:0]                                    state_dbg
`ifdef MATMUL_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]                                   perf_cycles,
  output logic [15:0]                                   perf_tiles
`endif
);

  import tpu_pkg::*;

  localparam int M_W  = $clog2(MAX_OUT_ROWS+1);
  localparam int N_W  = $clog2(MAX_OUT_COLS+1);
  localparam int K_W  = $clog2(MAX_INTERMED+1);
  localparam int TR_W = $clog2(MAX_OUT_ROWS/SYS_ARR_DIM);
  localparam int TC_W = $clog2(MAX_OUT_COLS/SYS_ARR_DIM);
  localparam int TK_W = $clog2(MAX_INTERMED/SYS_ARR_DIM);

  sched_state_e state, state_nx;

  logic [TR_W-1:0]   lim_r;
  logic [TC_W-1:0]   lim_c;
  logic [TK_W-1:0]   lim_k;
  logic [ADDR_W-1:0] base_weight_q, base_data_q;
  logic [M_W-1:0]    m_cl;
  logic [N_W-1:0]    n_cl;
  logic [K_W-1:0]    k_cl;
  logic              accept, dims_zero, advance, last;

  assign accept    = (state == S_IDLE) && start;
  assign dims_zero = (num_out_rows == '0) || (num_out_cols == '0) || (intermed_dim == '0);
  assign m_cl = (num_out_rows > M_W'(MAX_OUT_ROWS)) ? M_W'(MAX_OUT_ROWS) : num_out_rows;
  assign n_cl = (num_out_cols > N_W'(MAX_OUT_COLS)) ? N_W'(MAX_OUT_COLS) : num_out_cols;
  assign k_cl = (intermed_dim > K_W'(MAX_INTERMED)) ? K_W'(MAX_INTERMED) : intermed_dim;

  // Limits are stored as tile count minus one; unused when a dimension is zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      lim_r         <= '0;
      lim_c         <= '0;
      lim_k         <= '0;
      base_weight_q <= '0;
      base_data_q   <= '0;
    end else if (accept) begin
      lim_r         <= TR_W'(tile_count(int'(m_cl), SYS_ARR_DIM) - 1);
      lim_c         <= TC_W'(tile_count(int'(n_cl), SYS_ARR_DIM) - 1);
      lim_k         <= TK_W'(tile_count(int'(k_cl), SYS_ARR_DIM) - 1);
      base_weight_q <= base_weight;
      base_data_q   <= base_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // mult_start is a one-cycle pulse in ISSUE; the tile is complete on the first
  // mult_done seen in WAIT, and mult_done in any other state is dropped.
  always_comb begin
    state_nx   = state;
    mult_start = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = dims_zero ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        mult_start = 1'b1;
        busy       = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (mult_done) state_nx = S_ADVANCE;
      end
      S_ADVANCE: begin
        busy = 1'b1;
        if (last) begin
          state_nx = S_DONE;
        end else begin
          advance  = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  tile_index_counter #(
    .R_W(TR_W),
    .C_W(TC_W),
    .K_W(TK_W)
  ) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .advance(advance),
    .lim_r  (lim_r),
    .lim_c  (lim_c),
    .lim_k  (lim_k),
    .idx_r  (tile_row),
    .idx_c  (tile_col),
    .idx_k  (tile_k),
    .last   (last)
  );

  // Offsets are computed wide and truncated, so address wrap is silent.
  assign weight_addr = base_weight_q + ADDR_W'((32'(tile_k) * (32'(lim_c) + 32'd1)
                       + 32'(tile_col)) * 32'(SYS_ARR_DIM));
  assign data_addr   = base_data_q + ADDR_W'((32'(tile_row) * (32'(lim_k) + 32'd1)
                       + 32'(tile_k)) * 32'(SYS_ARR_DIM));
  assign accum_clear = busy && (tile_k == '0);
  assign state_dbg   = state;

`ifdef MATMUL_TILE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      perf_cycles <= '0;
      perf_tiles  <= '0;
    end else begin
      if (busy)       perf_cycles <= perf_cycles + 32'd1;
      if (mult_start) perf_tiles  <= perf_tiles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: directed scenarios plus random operations
// checked against a nested-loop tile model. Perf checks under MATMUL_TILE_SCHED_PERF_EN.
module tb_matmul_tile_scheduler;

  logic        clk, reset, start, mult_done;
  logic [7:0]  num_out_rows, num_out_cols, intermed_dim;
  logic [15:0] base_weight, base_data;
  logic        mult_start, accum_clear, busy, done;
  logic [2:0]  tile_row, tile_col, tile_k, state_dbg;
  logic [15:0] weight_addr, data_addr;
`ifdef MATMUL_TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_tiles;
`endif

  matmul_tile_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_out_rows(num_out_rows),
    .num_out_cols(num_out_cols),
    .intermed_dim(intermed_dim),
    .base_weight (base_weight),
    .base_data   (base_data),
    .mult_done   (mult_done),
    .mult_start  (mult_start),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .tile_k      (tile_k),
    .weight_addr (weight_addr),
    .data_addr   (data_addr),
    .accum_clear (accum_clear),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
`ifdef MATMUL_TILE_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_tiles  (perf_tiles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed tile: {row[3], col[3], k[3], weight_addr[16], data_addr[16]}
  logic [40:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: enumerate tiles row-major with k innermost, addresses by formula.
  task automatic build_model(input int m, input int n, input int k, input int bw, input int bd);
    int mc, nc, kc, rt, ct, kt, wa, da;
    logic [40:0] ent;
    exp_q.delete();
    mc = (m > 128) ? 128 : m;
    nc = (n > 128) ? 128 : n;
    kc = (k > 128) ? 128 : k;
    rt = (mc + 15) / 16;
    ct = (nc + 15) / 16;
    kt = (kc + 15) / 16;
    for (int r = 0; r < rt; r++)
      for (int c = 0; c < ct; c++)
        for (int kk = 0; kk < kt; kk++) begin
          wa  = (bw + (kk * ct + c) * 16) % 65536;
          da  = (bd + (r * kt + kk) * 16) % 65536;
          ent = {3'(r), 3'(c), 3'(kk), 16'(wa), 16'(da)};
          exp_q.push_back(ent);
        end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_mstart"}, {31'd0, mult_start}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_aclr"}, {31'd0, accum_clear}, 0);
    check({tag, "_tiles"}, {23'd0, tile_row, tile_col, tile_k}, 0);
    check({tag, "_waddr"}, {16'd0, weight_addr}, 0);
    check({tag, "_daddr"}, {16'd0, data_addr}, 0);
  endtask

  // ---------------- driver ----------------
  // lat_fixed = 0 picks a random mult_done latency; abort_at >= 0 resets in that tile's WAIT.
  task automatic run_op(input int m, input int n, input int k, input int bw, input int bd,
                        input int lat_fixed, input int abort_at);
    logic [40:0] e;
    int idx, lat, ms_cyc;
    build_model(m, n, k, bw, bd);
    num_out_rows = 8'(m);
    num_out_cols = 8'(n);
    intermed_dim = 8'(k);
    base_weight  = 16'(bw);
    base_data    = 16'(bd);
    start = 1'b1;
    step();
    start = 1'b0;
    if (exp_q.size() == 0) begin
      check("zero_done", {31'd0, done}, 1);
      check("zero_mstart", {31'd0, mult_start}, 0);
      check("zero_busy", {31'd0, busy}, 0);
      step();
      check("zero_done_clr", {31'd0, done}, 0);
      check("zero_mstart2", {31'd0, mult_start}, 0);
      return;
    end
    idx = 0;
    ms_cyc = 0;
    lat = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ms_cyc = cyc;
      check("mult_start", {31'd0, mult_start}, 1);
      check("busy_issue", {31'd0, busy}, 1);
      check("tile_row", {29'd0, tile_row}, {29'd0, e[40:38]});
      check("tile_col", {29'd0, tile_col}, {29'd0, e[37:35]});
      check("tile_k", {29'd0, tile_k}, {29'd0, e[34:32]});
      check("weight_addr", {16'd0, weight_addr}, {16'd0, e[31:16]});
      check("data_addr", {16'd0, data_addr}, {16'd0, e[15:0]});
      check("accum_clear", {31'd0, accum_clear}, {31'd0, e[34:32] == 3'd0});
      // Stray mult_done in ISSUE and a stray start mid-operation must both be ignored.
      mult_done = 1'($urandom_range(0, 1));
      if (idx == 1) begin
        start = 1'b1;
        num_out_rows = 8'd5;
        num_out_cols = 8'd100;
        intermed_dim = 8'd0;
        base_weight  = 16'($urandom);
        base_data    = 16'($urandom);
      end
      step();
      mult_done = 1'b0;
      start = 1'b0;
      check("wait_mstart", {31'd0, mult_start}, 0);
      check("wait_busy", {31'd0, busy}, 1);
      if (idx == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_zero("abort");
        step();
        check("abort_no_done", {31'd0, done}, 0);
        exp_q.delete();
        return;
      end
      lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 4);
      repeat (lat - 1) step();
      check("hold_waddr", {16'd0, weight_addr}, {16'd0, e[31:16]});
      mult_done = 1'b1;
      step();
      mult_done = 1'b0;
      check("adv_busy", {31'd0, busy}, 1);
      check("adv_mstart", {31'd0, mult_start}, 0);
      check("adv_hold_k", {29'd0, tile_k}, {29'd0, e[34:32]});
      step();
      idx++;
    end
    check("done", {31'd0, done}, 1);
    check("done_busy", {31'd0, busy}, 0);
    check("done_mstart", {31'd0, mult_start}, 0);
    check("done_latency", cyc - ms_cyc, lat + 2);
    step();
    check("done_clr", {31'd0, done}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    mult_done = 1'b0;
    num_out_rows = '0;
    num_out_cols = '0;
    intermed_dim = '0;
    base_weight  = '0;
    base_data    = '0;
    step();
    step();
    check_idle_zero("reset");
    reset = 1'b0;
    step();

    run_op(32, 32, 32, 16'h1000, 16'h2000, 0, -1);
    run_op(16, 16, 16, 16'h0100, 16'h0200, 3, -1);
    run_op(20, 16, 40, 16'h4000, 16'h8000, 0, -1);
    run_op(16, 16, 0, 16'h1234, 16'h5678, 0, -1);
    run_op(32, 32, 32, 16'h0300, 16'h0400, 0, 2);
    run_op(16, 16, 16, 16'h0500, 16'h0600, 0, -1);
    run_op(255, 16, 16, 16'hFFF0, 16'hFF00, 0, -1);
    run_op(0, 40, 40, 16'h0000, 16'h0000, 0, -1);

`ifdef MATMUL_TILE_SCHED_PERF_EN
    run_op(32, 32, 32, 16'h0000, 16'h0000, 1, -1);
    check("perf_tiles", {16'd0, perf_tiles}, 8);
    check("perf_cycles", perf_cycles, 24);
    step();
    check("perf_cycles_hold", perf_cycles, 24);
`endif

    for (int i = 0; i < 8; i++) begin
      run_op($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 60),
             $urandom_range(1, 60),
             $urandom_range(1, 150),
             $urandom_range(0, 65535), $urandom_range(0, 65535), 0, -1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
